// File: rtl/doodle_steer.sv
// doodle_steer: turns the raw left/right push-buttons into the signed
// per-frame horizontal step consumed by the doodle sprite block.
//
// The buttons are synchronised and debounced. A per-frame state machine then
// ramps the speed up while one direction is held and brakes it down when the
// button is released. The block runs its own frame timebase with the same
// CLK/FPS period as the sprite, so delta_x only changes at a frame boundary.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous reset, active-low (0 = reset)
//   btn_left    in   raw button, active-high, asynchronous to clk
//   btn_right   in   raw button, active-high, asynchronous to clk
//   delta_x     out  signed 9-bit step per frame, negative = left
//   facing_left out  last commanded direction, 1 = left
//   frame_tick  out  one-cycle pulse on the last cycle of each frame
module doodle_steer #(
  parameter int CLK             = 50000000,
  parameter int FPS             = 50,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_SPEED       = 8,
  parameter int ACCEL           = 2,
  parameter int DECEL           = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic signed [8:0] delta_x,
  output logic              facing_left,
  output logic              frame_tick
);

  localparam int FRAME_LEN = CLK / FPS;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_BRAKE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LEFT  = 2'd1,
    CMD_RIGHT = 2'd2
  } cmd_e;

  // Accelerate: the sum is formed in 9 bits so a large speed never wraps
  // before the clamp to MAX_SPEED.
  function automatic logic [7:0] speed_up(input logic [7:0] s);
    logic [8:0] sum;
    sum = {1'b0, s} + 9'(ACCEL);
    if (sum > 9'(MAX_SPEED)) begin
      speed_up = 8'(MAX_SPEED);
    end else begin
      speed_up = sum[7:0];
    end
  endfunction

  // Brake: subtract DECEL, clamping at zero.
  function automatic logic [7:0] speed_down(input logic [7:0] s);
    if ({1'b0, s} > 9'(DECEL)) begin
      speed_down = s - 8'(DECEL);
    end else begin
      speed_down = 8'd0;
    end
  endfunction

  // Index 0 = left button, index 1 = right button.
  logic [1:0]    sync0_q, sync0_d;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    db_q, db_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          frame_tick_q, frame_tick_d;
  logic          tick_now_s;

  state_e            state_q, state_d;
  cmd_e              cmd_s;
  logic [7:0]        speed_q, speed_d;
  logic              facing_q, facing_d;
  logic signed [8:0] delta_x_q, delta_x_d;

  // Synchroniser shift and per-button debounce counters.
  always_comb begin
    sync0_d = {btn_right, btn_left};
    sync1_d = sync0_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      if (sync1_q[i] != db_q[i]) begin
        // The level has differed for DEBOUNCE_CYCLES cycles once the counter
        // sits at its last value with the mismatch still present.
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]     = ~db_q[i];
          db_cnt_d[i] = {DW{1'b0}};
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        db_cnt_d[i] = {DW{1'b0}};
      end
    end
  end

  // Frame timebase: wraps at FRAME_LAST; the tick flop is loaded with the
  // next count so it is high exactly while the counter holds FRAME_LAST.
  always_comb begin
    tick_now_s = (frame_cnt_q == FRAME_LAST);
    if (tick_now_s) begin
      frame_cnt_d = {CW{1'b0}};
    end else begin
      frame_cnt_d = frame_cnt_q + CW'(1);
    end
    frame_tick_d = (frame_cnt_d == FRAME_LAST);
  end

  // Command decode: both or neither pressed means no input.
  always_comb begin
    if (db_q[0] && !db_q[1]) begin
      cmd_s = CMD_LEFT;
    end else if (db_q[1] && !db_q[0]) begin
      cmd_s = CMD_RIGHT;
    end else begin
      cmd_s = CMD_NONE;
    end
  end

  // Speed/direction state machine, advanced only on frame ticks.
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    facing_d = facing_q;
    if (tick_now_s) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_s == CMD_LEFT) begin
            state_d  = ST_LEFT;
            speed_d  = speed_up(8'd0);
            facing_d = 1'b1;
          end else if (cmd_s == CMD_RIGHT) begin
            state_d  = ST_RIGHT;
            speed_d  = speed_up(8'd0);
            facing_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEFT: begin
          if (cmd_s == CMD_LEFT) begin
            speed_d = speed_up(speed_q);
          end else begin
            state_d = ST_BRAKE;
            speed_d = speed_down(speed_q);
          end
        end
        ST_RIGHT: begin
          if (cmd_s == CMD_RIGHT) begin
            speed_d = speed_up(speed_q);
          end else begin
            state_d = ST_BRAKE;
            speed_d = speed_down(speed_q);
          end
        end
        ST_BRAKE: begin
          if (speed_q == 8'd0) begin
            // Fully stopped: free to start in either direction.
            if (cmd_s == CMD_LEFT) begin
              state_d  = ST_LEFT;
              speed_d  = speed_up(8'd0);
              facing_d = 1'b1;
            end else if (cmd_s == CMD_RIGHT) begin
              state_d  = ST_RIGHT;
              speed_d  = speed_up(8'd0);
              facing_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if ((cmd_s == CMD_LEFT && facing_q) ||
                       (cmd_s == CMD_RIGHT && !facing_q)) begin
            // Same direction pressed again: resume accelerating from the
            // current speed. A reversal keeps braking until speed is zero.
            state_d = facing_q ? ST_LEFT : ST_RIGHT;
            speed_d = speed_up(speed_q);
          end else begin
            speed_d = speed_down(speed_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (facing_d) begin
      delta_x_d = 9'sd0 - $signed({1'b0, speed_d});
    end else begin
      delta_x_d = $signed({1'b0, speed_d});
    end
  end

  // All state registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync0_q      <= 2'b00;
      sync1_q      <= 2'b00;
      db_q         <= 2'b00;
      db_cnt_q[0]  <= {DW{1'b0}};
      db_cnt_q[1]  <= {DW{1'b0}};
      frame_cnt_q  <= {CW{1'b0}};
      frame_tick_q <= 1'b0;
      state_q      <= ST_IDLE;
      speed_q      <= 8'd0;
      facing_q     <= 1'b0;
      delta_x_q    <= 9'sd0;
    end else begin
      sync0_q      <= sync0_d;
      sync1_q      <= sync1_d;
      db_q         <= db_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      speed_q      <= speed_d;
      facing_q     <= facing_d;
      delta_x_q    <= delta_x_d;
    end
  end

  assign delta_x     = delta_x_q;
  assign facing_left = facing_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_doodle_steer.sv
// Bench for doodle_steer with a 100-cycle frame and 4-cycle debounce.
// Expected per-frame (delta_x, facing_left) pairs are queued when buttons
// are driven and popped on the cycle after each frame tick.
module tb_doodle_steer;

  logic              clk;
  logic              rst;
  logic              btn_left;
  logic              btn_right;
  logic signed [8:0] delta_x;
  logic              facing_left;
  logic              frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [8:0] dx;
    logic              fl;
  } exp_t;

  exp_t sb_q[$];

  doodle_steer #(
    .CLK(1000),
    .FPS(10),
    .DEBOUNCE_CYCLES(4),
    .MAX_SPEED(8),
    .ACCEL(2),
    .DECEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .delta_x(delta_x),
    .facing_left(facing_left),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int dx, input logic fl);
    exp_t e;
    e.dx = 9'(dx);
    e.fl = fl;
    sb_q.push_back(e);
  endtask

  // Wait for the next frame tick, then step to #1 after the edge ending it.
  task automatic wait_tick_edge();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 250) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare n frames against the scoreboard.
  task automatic check_frames(input int n, input string tag);
    exp_t e;
    for (int f = 0; f < n; f++) begin
      wait_tick_edge();
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_sb_empty: frame %0d has no expectation", tag, f);
      end else begin
        e = sb_q.pop_front();
        if (delta_x !== e.dx) begin
          errors++;
          $display("FAIL %s_delta frame %0d: got %0d expected %0d", tag, f, delta_x, e.dx);
        end
        checks++;
        if (facing_left !== e.fl) begin
          errors++;
          $display("FAIL %s_facing frame %0d: got %0b expected %0b", tag, f, facing_left, e.fl);
        end
      end
    end
  endtask

  // After a reset release, the tick must appear only after exactly 99 edges.
  task automatic check_tick_timing(input int edges, input string tag);
    logic exp_tick;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk);
      #1;
      exp_tick = (k == 99 || k == 199);
      checks++;
      if (frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL %s_tick at edge %0d: got %0b expected %0b", tag, k, frame_tick, exp_tick);
      end
    end
    checks++;
    if (delta_x !== 9'sd0) begin
      errors++;
      $display("FAIL %s_idle_delta: got %0d expected 0", tag, delta_x);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (delta_x !== 9'sd0) begin
      errors++;
      $display("FAIL %s_delta: got %0d expected 0", tag, delta_x);
    end
    checks++;
    if (facing_left !== 1'b0) begin
      errors++;
      $display("FAIL %s_facing: got %0b expected 0", tag, facing_left);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s_tick: got %0b expected 0", tag, frame_tick);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    check_tick_timing(200, "reset");
  endtask

  task automatic test_hold_right();
    btn_right = 1'b1;
    push_exp(2, 1'b0); push_exp(4, 1'b0); push_exp(6, 1'b0);
    push_exp(8, 1'b0); push_exp(8, 1'b0); push_exp(8, 1'b0);
    check_frames(6, "hold_right");
  endtask

  task automatic test_release();
    btn_right = 1'b0;
    for (int v = 7; v >= 0; v--) push_exp(v, 1'b0);
    push_exp(0, 1'b0);
    push_exp(0, 1'b0);
    check_frames(10, "release");
  endtask

  task automatic test_reverse();
    btn_right = 1'b1;
    push_exp(2, 1'b0); push_exp(4, 1'b0); push_exp(6, 1'b0); push_exp(8, 1'b0);
    check_frames(4, "reverse_ramp");
    btn_right = 1'b0;
    btn_left = 1'b1;
    for (int v = 7; v >= 0; v--) push_exp(v, 1'b0);
    push_exp(-2, 1'b1); push_exp(-4, 1'b1); push_exp(-6, 1'b1); push_exp(-8, 1'b1);
    check_frames(12, "reverse");
  endtask

  task automatic test_glitch_both();
    // Brake back to IDLE from -8; facing stays left throughout.
    btn_left = 1'b0;
    for (int v = 7; v >= 1; v--) push_exp(-v, 1'b1);
    push_exp(0, 1'b1);
    push_exp(0, 1'b1);
    check_frames(9, "left_release");
    // A 3-cycle pulse is one cycle short of the debounce window.
    repeat (20) @(posedge clk);
    #1;
    btn_left = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_left = 1'b0;
    push_exp(0, 1'b1);
    push_exp(0, 1'b1);
    check_frames(2, "glitch");
    btn_left = 1'b1;
    btn_right = 1'b1;
    push_exp(0, 1'b1); push_exp(0, 1'b1); push_exp(0, 1'b1);
    check_frames(3, "both");
    btn_left = 1'b0;
    btn_right = 1'b0;
    push_exp(0, 1'b1);
    check_frames(1, "both_release");
  endtask

  task automatic test_reset_mid_ramp();
    btn_right = 1'b1;
    push_exp(2, 1'b0); push_exp(4, 1'b0); push_exp(6, 1'b0);
    check_frames(3, "mid_ramp");
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    btn_right = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    check_tick_timing(100, "mid_reset");
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    test_reset();
    test_hold_right();
    test_release();
    test_reverse();
    test_glitch_both();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
